// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/MEM requesters and the memory port arbiter.
// Requests flow in; mux select, strobes, acks and stalls flow out.
interface mem_port_arbiter_if;
  logic if_req;
  logic mem_rd_req;
  logic mem_wr_req;
  logic addr_sel;
  logic port_rd;
  logic port_wr;
  logic if_ack;
  logic mem_ack;
  logic if_stall;
  logic mem_stall;
  logic busy;

  modport master (
    output if_req, mem_rd_req, mem_wr_req,
    input  addr_sel, port_rd, port_wr,
    input  if_ack, mem_ack,
    input  if_stall, mem_stall, busy
  );

  modport slave (
    input  if_req, mem_rd_req, mem_wr_req,
    output addr_sel, port_rd, port_wr,
    output if_ack, mem_ack,
    output if_stall, mem_stall, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter: MEM wins ties, a starvation
// counter forces an IF grant after STARVE_MAX consecutive IF losses.
module mem_port_arbiter #(
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 3
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_IF  = 2'd1,
    SERVE_MEM = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] lat_q, lat_d;
  logic [3:0] starve_q, starve_d;
  logic       is_wr_q, is_wr_d;

  logic mem_any;
  logic last;
  logic arb;
  logic if_win;

  assign mem_any = bus.mem_rd_req | bus.mem_wr_req;
  assign last    = (lat_q == 4'd0);
  assign arb     = (state_q == IDLE) | last;
  assign if_win  = bus.if_req &
                   (~mem_any | (starve_q == 4'(STARVE_MAX)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lat_q    <= 4'd0;
      starve_q <= 4'd0;
      is_wr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      is_wr_q  <= is_wr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    is_wr_d  = is_wr_q;
    if (!arb) begin
      lat_d = lat_q - 4'd1;
    end else if (if_win) begin
      state_d  = SERVE_IF;
      lat_d    = 4'(LAT - 1);
      starve_d = 4'd0;
    end else if (mem_any) begin
      state_d = SERVE_MEM;
      lat_d   = 4'(LAT - 1);
      // Both strobes high is a protocol error; the write wins.
      is_wr_d = bus.mem_wr_req;
      if (bus.if_req) begin
        starve_d = (starve_q == 4'hF) ? 4'hF
                                      : starve_q + 4'd1;
      end else begin
        starve_d = 4'd0;
      end
    end else begin
      state_d  = IDLE;
      lat_d    = 4'd0;
      starve_d = 4'd0;
    end
  end

  assign bus.addr_sel  = (state_q == SERVE_MEM);
  assign bus.port_rd   = (state_q == SERVE_IF) |
                         ((state_q == SERVE_MEM) & ~is_wr_q);
  assign bus.port_wr   = (state_q == SERVE_MEM) & is_wr_q;
  assign bus.if_ack    = (state_q == SERVE_IF) & last;
  assign bus.mem_ack   = (state_q == SERVE_MEM) & last;
  assign bus.busy      = (state_q != IDLE);
  assign bus.if_stall  = bus.if_req & ~bus.if_ack;
  assign bus.mem_stall = mem_any & ~bus.mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (LAT 1/2/3), directed
// scenarios plus randomized traffic against a per-instance service model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic       ifr [3];
  logic       rdr [3];
  logic       wrr [3];
  logic [7:0] obs [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter_if bus ();
    mem_port_arbiter #(
      .LAT        (g + 1),
      .STARVE_MAX ((g == 2) ? 2 : 3)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.if_req     = ifr[g];
    assign bus.mem_rd_req = rdr[g];
    assign bus.mem_wr_req = wrr[g];
    assign obs[g] = {bus.addr_sel, bus.port_rd, bus.port_wr,
                     bus.if_ack, bus.mem_ack,
                     bus.if_stall, bus.mem_stall, bus.busy};
  end

  function automatic int lat_of(int k);
    return k + 1;
  endfunction

  function automatic int sm_of(int k);
    return (k == 2) ? 2 : 3;
  endfunction

  task automatic clear_reqs();
    for (int k = 0; k < 3; k++) begin
      ifr[k] = 1'b0;
      rdr[k] = 1'b0;
      wrr[k] = 1'b0;
    end
  endtask

  task automatic idle(int n);
    clear_reqs();
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_reqs();
    #2;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs[k] !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_idle k=%0d got=%b want=%b",
                 k, obs[k], 8'h00);
      end
    end
    for (int k = 0; k < 3; k++) begin
      ifr[k] = 1'b1;
      rdr[k] = 1'b1;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs[k] !== 8'h06) begin
        n_bad++;
        $display("FAIL reset_stall k=%0d got=%b want=%b",
                 k, obs[k], 8'h06);
      end
    end
    clear_reqs();
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
  endtask

  task automatic test_if_stream();
    logic [7:0] e;
    ifr[0] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      e = (c == 0) ? 8'h04 : 8'h51;
      @(negedge clk);
      n_cmp++;
      if (obs[0] !== e) begin
        n_bad++;
        $display("FAIL if_stream c=%0d got=%b want=%b", c, obs[0], e);
      end
      @(posedge clk);
      #1;
    end
    idle(4);
  endtask

  task automatic test_mem_priority();
    logic [7:0] e [6] = '{8'h06, 8'hC7, 8'hCD, 8'h45, 8'h51, 8'h00};
    ifr[1] = 1'b1;
    rdr[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) rdr[1] = 1'b0;
      if (c == 4) ifr[1] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs[1] !== e[c]) begin
        n_bad++;
        $display("FAIL mem_priority c=%0d got=%b want=%b",
                 c, obs[1], e[c]);
      end
      @(posedge clk);
      #1;
    end
    idle(4);
  endtask

  task automatic test_starvation();
    logic [7:0] e;
    ifr[0] = 1'b1;
    rdr[0] = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c == 0)          e = 8'h06;
      else if (c % 4 == 0) e = 8'h53;
      else                 e = 8'hCD;
      @(negedge clk);
      n_cmp++;
      if (obs[0] !== e) begin
        n_bad++;
        $display("FAIL starvation c=%0d got=%b want=%b", c, obs[0], e);
      end
      @(posedge clk);
      #1;
    end
    idle(4);
  endtask

  task automatic test_write_latency();
    logic [7:0] e [5] = '{8'h02, 8'hA3, 8'hA3, 8'hA9, 8'h00};
    wrr[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) wrr[2] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs[2] !== e[c]) begin
        n_bad++;
        $display("FAIL write_latency c=%0d got=%b want=%b",
                 c, obs[2], e[c]);
      end
      @(posedge clk);
      #1;
    end
    idle(4);
  endtask

  task automatic test_reset_abort();
    logic [7:0] e [8] = '{8'h02, 8'hC3, 8'hC3, 8'h02,
                          8'hC3, 8'hC3, 8'hC9, 8'h00};
    rdr[2] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) rdr[2] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs[2] !== e[c]) begin
        n_bad++;
        $display("FAIL reset_abort c=%0d got=%b want=%b",
                 c, obs[2], e[c]);
      end
      if (c == 2) begin
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (obs[2] !== 8'h02) begin
          n_bad++;
          $display("FAIL reset_abort_now got=%b want=%b",
                   obs[2], 8'h02);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (obs[2] !== 8'h02) begin
          n_bad++;
          $display("FAIL reset_abort_hold got=%b want=%b",
                   obs[2], 8'h02);
        end
        rst = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    idle(4);
  endtask

  task automatic test_both_req();
    logic [7:0] e [4] = '{8'h02, 8'hA3, 8'hA9, 8'h00};
    rdr[1] = 1'b1;
    wrr[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin
        rdr[1] = 1'b0;
        wrr[1] = 1'b0;
      end
      @(negedge clk);
      n_cmp++;
      if (obs[1] !== e[c]) begin
        n_bad++;
        $display("FAIL both_req c=%0d got=%b want=%b",
                 c, obs[1], e[c]);
      end
      @(posedge clk);
      #1;
    end
    idle(4);
  endtask

  // Model: who owns the port, how many service cycles remain
  // (counting the current one), and how often IF has lost in a row.
  task automatic test_random();
    int   own  [3];
    int   left [3];
    int   loss [3];
    bit   mwr  [3];
    bit   ma, win;
    int   r;
    logic [7:0] e;
    for (int k = 0; k < 3; k++) begin
      own[k]  = 0;
      left[k] = 0;
      loss[k] = 0;
      mwr[k]  = 1'b0;
    end
    for (int cy = 0; cy < 600; cy++) begin
      for (int k = 0; k < 3; k++) begin
        if (!ifr[k] || (own[k] == 1 && left[k] == 1))
          ifr[k] = ($urandom_range(2) != 0);
        if (!(rdr[k] || wrr[k]) || (own[k] == 2 && left[k] == 1)) begin
          r = $urandom_range(7);
          rdr[k] = (r >= 3 && r <= 5) || r == 7;
          wrr[k] = (r >= 6);
        end
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        e[7] = (own[k] == 2);
        e[6] = (own[k] == 1) || (own[k] == 2 && !mwr[k]);
        e[5] = (own[k] == 2) && mwr[k];
        e[4] = (own[k] == 1) && (left[k] == 1);
        e[3] = (own[k] == 2) && (left[k] == 1);
        e[2] = ifr[k] && !e[4];
        e[1] = (rdr[k] || wrr[k]) && !e[3];
        e[0] = (own[k] != 0);
        n_cmp++;
        if (obs[k] !== e) begin
          n_bad++;
          $display("FAIL random k=%0d cy=%0d got=%b want=%b",
                   k, cy, obs[k], e);
        end
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (own[k] == 0 || left[k] == 1) begin
          ma  = rdr[k] || wrr[k];
          win = ifr[k] && (!ma || loss[k] == sm_of(k));
          if (win) begin
            own[k]  = 1;
            left[k] = lat_of(k);
            loss[k] = 0;
          end else if (ma) begin
            own[k]  = 2;
            left[k] = lat_of(k);
            mwr[k]  = wrr[k];
            loss[k] = ifr[k] ? ((loss[k] < 15) ? loss[k] + 1 : 15) : 0;
          end else begin
            own[k]  = 0;
            left[k] = 0;
            loss[k] = 0;
          end
        end else begin
          left[k] = left[k] - 1;
        end
      end
      #1;
    end
    idle(4);
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_if_stream();
    test_mem_priority();
    test_starvation();
    test_write_latency();
    test_reset_abort();
    test_both_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
